// File: rtl/dec38_hold.sv
// Registered 3-to-8 decoder for the encode2seg LED bank: rebuilds a one-hot
// pattern from the encoder code, holds it briefly after valid drops, counts code changes.
module dec38_hold #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic [3:0]       code_in,
    output logic [7:0]       onehot_out,
    output logic             active,
    output logic [CNT_W-1:0] chg_cnt,
    output logic [1:0]       dbg_state
);

    localparam int HC_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HC_W'(HOLD_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_onehot;
    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [HC_W-1:0]  r_hold;
    logic [2:0]       r_last;

    logic             w_legal;
    logic [7:0]       w_pat;
    logic             w_diff;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_legal   = valid_in & ~code_in[3];
    assign w_pat     = 8'd1 << code_in[2:0];
    assign w_diff    = (code_in[2:0] != r_last);
    // Saturate at all-ones so the debug readout never wraps back to a small value.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_onehot <= 8'h00;
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_last   <= 3'b000;
        end else if (!en) begin
            r_state  <= IDLE;
            r_onehot <= 8'h00;
            r_active <= 1'b0;
            r_hold   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_state  <= SHOW;
                        r_onehot <= w_pat;
                        r_active <= 1'b1;
                        r_last   <= code_in[2:0];
                        r_cnt    <= w_cnt_inc;
                    end
                end
                SHOW, HOLD: begin
                    if (w_legal) begin
                        r_state  <= SHOW;
                        r_onehot <= w_pat;
                        r_active <= 1'b1;
                        r_last   <= code_in[2:0];
                        r_hold   <= '0;
                        if (w_diff) r_cnt <= w_cnt_inc;
                    end else if (r_state == SHOW && HOLD_CYCLES > 0) begin
                        r_state <= HOLD;
                        r_hold  <= HOLD_LOAD;
                    end else if (r_state == HOLD && r_hold != '0) begin
                        r_hold <= r_hold - HC_W'(1);
                    end else begin
                        r_state  <= IDLE;
                        r_onehot <= 8'h00;
                        r_active <= 1'b0;
                        r_hold   <= '0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_onehot <= 8'h00;
                    r_active <= 1'b0;
                    r_hold   <= '0;
                end
            endcase
        end
    end

    assign onehot_out = r_onehot;
    assign active     = r_active;
    assign chg_cnt    = r_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_dec38_hold.sv
// Scoreboard bench for dec38_hold: a HOLD_CYCLES=4 main instance plus a
// HOLD_CYCLES=0 instance sharing the same inputs.
module tb_dec38_hold;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       valid_in = 1'b0;
    logic [3:0] code_in = 4'h0;

    logic [7:0] onehot_out, onehot0;
    logic       active, active0;
    logic [7:0] chg_cnt, chg_cnt0;
    logic [1:0] dbg_state, dbg_state0;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [7:0] oh;
        logic [7:0] cnt;
        logic       chk0;
        logic [7:0] oh0;
    } exp_t;

    exp_t exp_q[$];

    dec38_hold #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .code_in(code_in),
        .onehot_out(onehot_out), .active(active), .chg_cnt(chg_cnt), .dbg_state(dbg_state)
    );

    dec38_hold #(.HOLD_CYCLES(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .code_in(code_in),
        .onehot_out(onehot0), .active(active0), .chg_cnt(chg_cnt0), .dbg_state(dbg_state0)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: apply on negedge, push expectation once the sampling edge has passed
    task automatic drive(input logic e, input logic v, input logic [3:0] c,
                         input logic [7:0] exp_oh, input logic [7:0] exp_cnt,
                         input logic chk0 = 1'b0, input logic [7:0] exp_oh0 = 8'h00);
        exp_t x;
        @(negedge clk);
        en = e; valid_in = v; code_in = c;
        @(posedge clk);
        x.oh = exp_oh; x.cnt = exp_cnt; x.chk0 = chk0; x.oh0 = exp_oh0;
        exp_q.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // monitor / scoreboard
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("onehot", onehot_out, x.oh);
                check("active", active, (x.oh != 8'h00));
                check("chg_cnt", chg_cnt, x.cnt);
                check("onehot0_inv", $onehot0(onehot_out), 1);
                if (x.chk0) begin
                    check("onehot_h0", onehot0, x.oh0);
                    check("active_h0", active0, (x.oh0 != 8'h00));
                end
            end
        end
    end

    initial begin
        logic [3:0] c;
        int exp_c;

        rst = 1'b1;
        #12;
        check("rst_onehot", onehot_out, 8'h00);
        check("rst_active", active, 0);
        check("rst_cnt", chg_cnt, 0);
        check("rst_state", dbg_state, 0);
        check("rst_onehot_h0", onehot0, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // single legal code 5
        drive(1, 1, 4'b0101, 8'h20, 8'd1, 1, 8'h20);
        // codes 7,7,3,3,0
        drive(1, 1, 4'd7, 8'h80, 8'd2, 1, 8'h80);
        drive(1, 1, 4'd7, 8'h80, 8'd2);
        drive(1, 1, 4'd3, 8'h08, 8'd3);
        drive(1, 1, 4'd3, 8'h08, 8'd3);
        drive(1, 1, 4'd0, 8'h01, 8'd4);
        // show 2, then hold through 4 invalid edges, clear on the 5th
        drive(1, 1, 4'd2, 8'h04, 8'd5, 1, 8'h04);
        drive(1, 0, 4'd0, 8'h04, 8'd5, 1, 8'h00);
        drive(1, 0, 4'd0, 8'h04, 8'd5);
        drive(1, 0, 4'd0, 8'h04, 8'd5);
        drive(1, 0, 4'd0, 8'h04, 8'd5);
        drive(1, 0, 4'd0, 8'h00, 8'd5);
        // IDLE->SHOW with same code still counts; recover from HOLD
        drive(1, 1, 4'd2, 8'h04, 8'd6);
        drive(1, 0, 4'd0, 8'h04, 8'd6);
        drive(1, 0, 4'd0, 8'h04, 8'd6);
        drive(1, 1, 4'd2, 8'h04, 8'd6);
        drive(1, 0, 4'd0, 8'h04, 8'd6);
        drive(1, 0, 4'd0, 8'h04, 8'd6);
        drive(1, 1, 4'd6, 8'h40, 8'd7, 1, 8'h40);
        // 4'b1111 with valid is invalid
        drive(1, 1, 4'd3, 8'h08, 8'd8, 1, 8'h08);
        drive(1, 1, 4'hF, 8'h08, 8'd8, 1, 8'h00);
        drive(1, 1, 4'hF, 8'h08, 8'd8);
        drive(1, 1, 4'hF, 8'h08, 8'd8);
        drive(1, 1, 4'hF, 8'h08, 8'd8);
        drive(1, 1, 4'hF, 8'h00, 8'd8, 1, 8'h00);
        // enable clear from SHOW and from HOLD
        drive(1, 1, 4'd1, 8'h02, 8'd9);
        drive(0, 1, 4'd1, 8'h00, 8'd9, 1, 8'h00);
        drive(1, 1, 4'd1, 8'h02, 8'd10);
        drive(1, 0, 4'd1, 8'h02, 8'd10);
        drive(0, 0, 4'd1, 8'h00, 8'd10);
        drive(1, 1, 4'd1, 8'h02, 8'd11);
        drive(1, 0, 4'd0, 8'h02, 8'd11);
        drain();

        // async reset mid-HOLD, between clock edges
        #2 rst = 1'b1;
        #1;
        check("async_onehot", onehot_out, 8'h00);
        check("async_active", active, 0);
        check("async_cnt", chg_cnt, 0);
        check("async_state", dbg_state, 0);
        #1 rst = 1'b0;
        drive(1, 1, 4'd0, 8'h01, 8'd1);

        // toggling codes 1/2 saturate the counter
        exp_c = 1;
        for (int i = 0; i < 300; i++) begin
            c = (i % 2 == 0) ? 4'd1 : 4'd2;
            exp_c = (exp_c < 255) ? exp_c + 1 : 255;
            drive(1, 1, c, (i % 2 == 0) ? 8'h02 : 8'h04, 8'(exp_c));
        end
        drive(1, 1, 4'd5, 8'h20, 8'd255);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
